// File: rtl/ps2_ascii_rx.sv
// PS/2 keyboard receiver: scan-code set 2 to ASCII strobes.
// Optional: PS2_REPEAT_FILTER_EN suppresses typematic repeats.
module ps2_ascii_rx #(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_out,
    output logic       p_valid,
    output logic       frame_err,
    output logic       shift_held,
    output logic [7:0] last_scan
);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } dec_st_t;

    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_LSH = 8'h12;
    localparam logic [7:0] SC_RSH = 8'h59;
    localparam logic [7:0] SC_ENT = 8'h5A;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_prev;
    logic                   fall;

    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] tmo;
    logic [7:0]       sh_data;
    logic             start_b;
    logic             par_b;
    logic             frame_ok;
    logic             byte_stb;

    dec_st_t    st;
    logic [9:0] map_res;
    logic       map_hit;
    logic       map_let;
    logic [7:0] map_chr;
    logic [7:0] emit_chr;
    logic       is_shift;

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] held;
`endif

    // Scan code lookup: {hit, is_letter, lowercase ascii}
    function automatic logic [9:0] map_code(
        input logic [7:0] sc
    );
        logic [9:0] r;
        r = 10'd0;
        case (sc)
            8'h1C: r = {2'b11, 8'h61};
            8'h32: r = {2'b11, 8'h62};
            8'h21: r = {2'b11, 8'h63};
            8'h23: r = {2'b11, 8'h64};
            8'h24: r = {2'b11, 8'h65};
            8'h2B: r = {2'b11, 8'h66};
            8'h34: r = {2'b11, 8'h67};
            8'h33: r = {2'b11, 8'h68};
            8'h43: r = {2'b11, 8'h69};
            8'h3B: r = {2'b11, 8'h6A};
            8'h42: r = {2'b11, 8'h6B};
            8'h4B: r = {2'b11, 8'h6C};
            8'h3A: r = {2'b11, 8'h6D};
            8'h31: r = {2'b11, 8'h6E};
            8'h44: r = {2'b11, 8'h6F};
            8'h4D: r = {2'b11, 8'h70};
            8'h15: r = {2'b11, 8'h71};
            8'h2D: r = {2'b11, 8'h72};
            8'h1B: r = {2'b11, 8'h73};
            8'h2C: r = {2'b11, 8'h74};
            8'h3C: r = {2'b11, 8'h75};
            8'h2A: r = {2'b11, 8'h76};
            8'h1D: r = {2'b11, 8'h77};
            8'h22: r = {2'b11, 8'h78};
            8'h35: r = {2'b11, 8'h79};
            8'h1A: r = {2'b11, 8'h7A};
            8'h45: r = {2'b10, 8'h30};
            8'h16: r = {2'b10, 8'h31};
            8'h1E: r = {2'b10, 8'h32};
            8'h26: r = {2'b10, 8'h33};
            8'h25: r = {2'b10, 8'h34};
            8'h2E: r = {2'b10, 8'h35};
            8'h36: r = {2'b10, 8'h36};
            8'h3D: r = {2'b10, 8'h37};
            8'h3E: r = {2'b10, 8'h38};
            8'h46: r = {2'b10, 8'h39};
            8'h29: r = {2'b10, 8'h20};
            8'h5A: r = {2'b10, 8'h0A};
            8'h66: r = {2'b10, 8'h08};
            default: r = 10'd0;
        endcase
        return r;
    endfunction

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    assign frame_ok = ~start_b
                    & (^{sh_data, par_b})
                    & dat_s;

    assign map_res  = map_code(last_scan);
    assign map_hit  = map_res[9];
    assign map_let  = map_res[8];
    assign map_chr  = map_res[7:0];
    assign emit_chr = (map_let && shift_held)
                    ? map_chr - 8'd32
                    : map_chr;
    assign is_shift = (last_scan == SC_LSH)
                    || (last_scan == SC_RSH);

    // Bring the asynchronous keyboard lines into clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_s;
        end
    end

    // Shift in frame bits on ps2_clk falls; check at stop bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= 4'd0;
            tmo       <= '0;
            sh_data   <= 8'd0;
            start_b   <= 1'b0;
            par_b     <= 1'b0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            last_scan <= 8'd0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tmo <= '0;
                if (bit_cnt == 4'd0) begin
                    start_b <= dat_s;
                end else if (bit_cnt <= 4'd8) begin
                    sh_data <= {dat_s, sh_data[7:1]};
                end else if (bit_cnt == 4'd9) begin
                    par_b <= dat_s;
                end
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        byte_stb  <= 1'b1;
                        last_scan <= sh_data;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // stalled partial frame is silently dropped
                if (tmo == TMO_LAST) begin
                    tmo     <= '0;
                    bit_cnt <= 4'd0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

    // Prefix/shift tracking and ASCII emit, one step per good byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            shift_held <= 1'b0;
            key_out    <= 8'd0;
            p_valid    <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            held       <= 8'd0;
`endif
        end else begin
            p_valid <= 1'b0;
            if (byte_stb) begin
                case (st)
                    IDLE: begin
                        if (last_scan == SC_BRK) begin
                            st <= BRK;
                        end else if (last_scan == SC_EXT) begin
                            st <= EXT;
                        end else if (is_shift) begin
                            shift_held <= 1'b1;
                        end else if (map_hit) begin
`ifdef PS2_REPEAT_FILTER_EN
                            if (last_scan != held) begin
                                key_out <= emit_chr;
                                p_valid <= 1'b1;
                                held    <= last_scan;
                            end
`else
                            key_out <= emit_chr;
                            p_valid <= 1'b1;
`endif
                        end
                    end
                    BRK: begin
                        if (is_shift) begin
                            shift_held <= 1'b0;
                        end
`ifdef PS2_REPEAT_FILTER_EN
                        if (last_scan == held) begin
                            held <= 8'd0;
                        end
`endif
                        st <= IDLE;
                    end
                    EXT: begin
                        if (last_scan == SC_BRK) begin
                            st <= EXT_BRK;
                        end else begin
                            st <= IDLE;
                            if (last_scan == SC_ENT) begin
                                key_out <= 8'h0A;
                                p_valid <= 1'b1;
                            end
                        end
                    end
                    EXT_BRK: begin
                        st <= IDLE;
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// Directed bench for ps2_ascii_rx: framing, decode, timeout, reset.
// Expected ASCII values are hand-computed from the scan-code table.
module tb_ps2_ascii_rx;

    localparam int TMO = 200;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_out;
    logic       p_valid;
    logic       frame_err;
    logic       shift_held;
    logic [7:0] last_scan;

    int n_cmp;
    int n_bad;
    int cyc;
    int stop_cyc;
    int pv_cyc;
    int dbl;
    int fe_cnt;
    logic pv_prev;
    logic [7:0] kq[$];

    ps2_ascii_rx #(
        .SYNC_STAGES(3),
        .TIMEOUT_CYC(TMO),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_out(key_out),
        .p_valid(p_valid),
        .frame_err(frame_err),
        .shift_held(shift_held),
        .last_scan(last_scan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (p_valid) begin
            kq.push_back(key_out);
            pv_cyc = cyc;
            if (pv_prev) dbl++;
        end
        pv_prev = p_valid;
        if (frame_err) fe_cnt++;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic send(
        input logic [7:0] b,
        input bit         badpar,
        input int         nbits
    );
        logic [10:0] fr;
        logic        par;
        par = ~(^b) ^ badpar;
        fr  = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b);
        send(b, 1'b0, 11);
    endtask

    int n0;
    int f0;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        dbl = 0; fe_cnt = 0; pv_prev = 1'b0;
        stop_cyc = 0; pv_cyc = 0;
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_key", 32'(key_out), 32'h0);
        check("rst_pv", 32'(p_valid), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        check("rst_sh", 32'(shift_held), 32'h0);
        check("rst_ls", 32'(last_scan), 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // single 1C frame
        n0 = kq.size();
        good(8'h1C);
        check("a_cnt", 32'(kq.size() - n0), 32'd1);
        check("a_key", 32'(kq[n0]), 32'h61);
        check("a_ls", 32'(last_scan), 32'h1C);
        check("a_lat", 32'(pv_cyc - stop_cyc), 32'd5);

        // shift make/break around letters
        n0 = kq.size();
        good(8'h12);
        check("s_held1", 32'(shift_held), 32'd1);
        good(8'h1C);
        good(8'hF0); good(8'h1C);
        check("s_held2", 32'(shift_held), 32'd1);
        good(8'hF0); good(8'h12);
        check("s_held3", 32'(shift_held), 32'd0);
        good(8'h1C);
        check("s_cnt", 32'(kq.size() - n0), 32'd2);
        check("s_up", 32'(kq[n0]), 32'h41);
        check("s_lo", 32'(kq[n0+1]), 32'h61);

        // bad parity frame dropped, then enter
        n0 = kq.size(); f0 = fe_cnt;
        send(8'h29, 1'b1, 11);
        check("p_fe", 32'(fe_cnt - f0), 32'd1);
        check("p_nopv", 32'(kq.size() - n0), 32'd0);
        check("p_ls", 32'(last_scan), 32'h1C);
        good(8'h5A);
        check("p_cnt", 32'(kq.size() - n0), 32'd1);
        check("p_key", 32'(kq[n0]), 32'h0A);

        // stalled partial frame times out silently
        n0 = kq.size(); f0 = fe_cnt;
        send(8'h1C, 1'b0, 4);
        repeat (TMO + 5) @(negedge clk);
        good(8'h29);
        check("t_fe", 32'(fe_cnt - f0), 32'd0);
        check("t_cnt", 32'(kq.size() - n0), 32'd1);
        check("t_key", 32'(kq[n0]), 32'h20);

        // extended enter, extended break, backspace
        n0 = kq.size();
        good(8'hE0); good(8'h5A);
        good(8'hE0); good(8'hF0); good(8'h5A);
        good(8'h66);
        check("e_cnt", 32'(kq.size() - n0), 32'd2);
        check("e_k0", 32'(kq[n0]), 32'h0A);
        check("e_k1", 32'(kq[n0+1]), 32'h08);

        // typematic repeat
        n0 = kq.size();
        good(8'h1C); good(8'h1C); good(8'h1C);
        good(8'hF0); good(8'h1C);
        good(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
        check("r_cnt", 32'(kq.size() - n0), 32'd2);
`else
        check("r_cnt", 32'(kq.size() - n0), 32'd4);
`endif
        check("r_k0", 32'(kq[n0]), 32'h61);
        check("r_kl", 32'(kq[kq.size()-1]), 32'h61);

        // reset mid-frame after a break prefix
        good(8'hF0);
        send(8'h1C, 1'b0, 5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("m_key", 32'(key_out), 32'h0);
        check("m_ls", 32'(last_scan), 32'h0);
        check("m_pv", 32'(p_valid), 32'h0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n0 = kq.size();
        good(8'h1C);
        check("m_cnt", 32'(kq.size() - n0), 32'd1);
        check("m_k", 32'(kq[n0]), 32'h61);
        check("m_ls2", 32'(last_scan), 32'h1C);

        check("pv_width", 32'(dbl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
